// File: rtl/shift_cmp_sequencer.sv
// Sequencer for an iterative 1-bit-per-cycle shifter followed by a signed/unsigned compare.
// Optional build macro SHIFT_CMP_SAT_EN: saturate left-shift results that overflowed.
module shift_cmp_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_thresh,
  input  logic [SHW-1:0]   cmd_shamt,
  input  logic             cmd_dir,
  input  logic             cmd_signed,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_gt,
  output logic             rsp_eq,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMPARE, RESP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] work, thresh;
  logic [SHW-1:0]   cnt;
  logic             dir, sgn, ovf;
  logic             accept;
  logic [WIDTH-1:0] step_val, final_val;
  logic             step_ovf, cmp_gt;
`ifdef SHIFT_CMP_SAT_EN
  logic             orig_neg;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = (state == IDLE) && !reset;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    accept     = cmd_valid && cmd_ready;
    unique case (state)
      IDLE:    if (accept) state_next = (cmd_shamt != '0) ? SHIFT : COMPARE;
      SHIFT:   if (cnt == SHW'(1)) state_next = COMPARE;
      COMPARE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shift step; signed left overflow means the sign bit changed.
  always_comb begin
    step_val = work;
    step_ovf = 1'b0;
    if (dir) begin
      step_val = {work[WIDTH-2:0], 1'b0};
      step_ovf = sgn ? (work[WIDTH-1] ^ work[WIDTH-2]) : work[WIDTH-1];
    end else begin
      step_val = {sgn & work[WIDTH-1], work[WIDTH-1:1]};
    end
  end

  always_comb begin
    final_val = work;
`ifdef SHIFT_CMP_SAT_EN
    if (dir && ovf) begin
      if (!sgn)          final_val = '1;
      else if (orig_neg) final_val = {1'b1, {(WIDTH-1){1'b0}}};
      else               final_val = {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    cmp_gt = sgn ? ($signed(final_val) > $signed(thresh)) : (final_val > thresh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work     <= '0;
      thresh   <= '0;
      cnt      <= '0;
      dir      <= 1'b0;
      sgn      <= 1'b0;
      ovf      <= 1'b0;
      rsp_data <= '0;
      rsp_gt   <= 1'b0;
      rsp_eq   <= 1'b0;
      rsp_ovf  <= 1'b0;
`ifdef SHIFT_CMP_SAT_EN
      orig_neg <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          work   <= cmd_data;
          thresh <= cmd_thresh;
          cnt    <= cmd_shamt;
          dir    <= cmd_dir;
          sgn    <= cmd_signed;
          ovf    <= 1'b0;
`ifdef SHIFT_CMP_SAT_EN
          orig_neg <= cmd_data[WIDTH-1];
`endif
        end
        SHIFT: begin
          work <= step_val;
          ovf  <= ovf | step_ovf;
          cnt  <= cnt - SHW'(1);
        end
        // Response registers only change here, so they stay put through RESP.
        COMPARE: begin
          rsp_data <= final_val;
          rsp_gt   <= cmp_gt;
          rsp_eq   <= (final_val == thresh);
          rsp_ovf  <= ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmp_sequencer.sv
// Scoreboard bench for shift_cmp_sequencer: directed commands push expectations, a monitor checks responses.
module tb_shift_cmp_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data, cmd_thresh;
  logic [3:0]  cmd_shamt;
  logic        cmd_dir, cmd_signed;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_gt, rsp_eq, rsp_ovf, busy;

  typedef struct {
    logic [15:0] data;
    logic        gt;
    logic        eq;
    logic        ovf;
    int          first;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] held_data;

  shift_cmp_sequencer #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_thresh(cmd_thresh), .cmd_shamt(cmd_shamt),
    .cmd_dir(cmd_dir), .cmd_signed(cmd_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [15:0] th, input logic [3:0] sh,
                               input logic dir, input logic sgn, input logic expect_rsp,
                               input logic [15:0] ed, input logic eg, input logic ee, input logic eo);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!cmd_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("issue_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_data   = d;
    cmd_thresh = th;
    cmd_shamt  = sh;
    cmd_dir    = dir;
    cmd_signed = sgn;
    cmd_valid  = 1'b1;
    if (expect_rsp) begin
      e.data  = ed;
      e.gt    = eg;
      e.eq    = ee;
      e.ovf   = eo;
      e.first = cyc + 1 + int'(sh) + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int w = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || busy) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: latency on rising rsp_valid, stability while stalled, field checks on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("latency", cyc, sb[0].first);
        end
        held_data = rsp_data;
      end else if (rsp_valid && prev_valid) begin
        checkOutput("rsp_stable", rsp_data, held_data);
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("rsp_data", rsp_data, e.data);
        checkOutput("rsp_gt", rsp_gt, e.gt);
        checkOutput("rsp_eq", rsp_eq, e.eq);
        checkOutput("rsp_ovf", rsp_ovf, e.ovf);
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_thresh = '0;
    cmd_shamt  = '0;
    cmd_dir    = 1'b0;
    cmd_signed = 1'b0;
    rsp_ready  = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_cmd_ready", cmd_ready, 1'b0);
      if (i > 0) begin
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_cmd_ready", cmd_ready, 1'b1);
    checkOutput("post_reset_rsp_data", rsp_data, 16'h0000);
    checkOutput("post_reset_rsp_valid", rsp_valid, 1'b0);

    // Right shifts, signed and unsigned fill
    applyStimulus(16'h8000, 16'h0000, 4'd3, 1'b0, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0);
    // Compare only
    applyStimulus(16'h7F00, 16'h8000, 4'd0, 1'b0, 1'b1, 1'b1, 16'h7F00, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h7F00, 16'h8000, 4'd0, 1'b0, 1'b0, 1'b1, 16'h7F00, 1'b0, 1'b0, 1'b0);
    // Left shifts with overflow
`ifdef SHIFT_CMP_SAT_EN
    applyStimulus(16'h4001, 16'h0000, 4'd1, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h4001, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'hC001, 16'h0004, 4'd2, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1);
`else
    applyStimulus(16'h4001, 16'h0000, 4'd1, 1'b1, 1'b1, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'h4001, 16'h0004, 4'd2, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'hC001, 16'h0004, 4'd2, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b1);
`endif
    // Maximum shift amounts without overflow
    applyStimulus(16'hFFFF, 16'h0001, 4'd15, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0001, 16'h7FFF, 4'd15, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
    waitDrain();

    // Back-pressure with ignored commands during the stall
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    applyStimulus(16'h8000, 16'hFFFF, 4'd15, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    begin
      int w = 0;
      @(negedge clk);
      while (!rsp_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      checkOutput("bp_rsp_valid", rsp_valid, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = ~cmd_valid;
      cmd_data  = 16'h1234;
      cmd_shamt = 4'd0;
      @(negedge clk);
      checkOutput("bp_cmd_ready", cmd_ready, 1'b0);
      checkOutput("bp_rsp_valid_held", rsp_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    waitDrain();

    // Reset in the middle of a long shift drops the command
    applyStimulus(16'h0100, 16'h0000, 4'd10, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_cmd_ready", cmd_ready, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("midreset_no_rsp", rsp_valid, 1'b0);
    applyStimulus(16'h0003, 16'h0006, 4'd1, 1'b1, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
